// File: rtl/display_scanner.sv
// rtl/display_scanner.sv - multiplexed seven-segment scan controller with frame-stable BCD shadow.
// Optional leading-zero blanking is enabled by defining LEADING_ZERO_BLANK_EN.
module display_scanner #(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 50000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   value_in,
  input  logic                  sign_in,
  input  logic                  load,
  output logic                  ack,
  output logic [3:0]            bcd_out,
  output logic                  blank,
  output logic                  minus,
  output logic [DIGITS-1:0]     digit_en
);

  localparam int IW = $clog2(DIGITS);
  localparam int PW = $clog2(REFRESH_DIV);
  localparam logic [IW-1:0] LAST_IDX  = IW'(DIGITS - 1);
  localparam logic [PW-1:0] PRESC_MAX = PW'(REFRESH_DIV - 1);

  logic [PW-1:0]         r_presc;
  logic [IW-1:0]         r_index;
  logic [4*DIGITS-1:0]   r_shadow_val;
  logic                  r_shadow_sign;
  logic [4*DIGITS-1:0]   r_pend_val;
  logic                  r_pend_sign;
  logic                  r_pending;
  logic                  r_ack;
  logic [3:0]            r_bcd;
  logic                  r_blank;
  logic                  r_minus;
  logic [DIGITS-1:0]     r_digit_en;

  logic                  w_tick;
  logic                  w_boundary;
  logic                  w_xfer;
  logic [4*DIGITS-1:0]   w_xfer_val;
  logic                  w_xfer_sign;
  logic [IW-1:0]         w_idx_nxt;
  logic [4*DIGITS-1:0]   w_shadow_nxt;
  logic                  w_sign_nxt;
  logic [3:0]            w_digit;
  logic [3:0]            w_bcd_nxt;
  logic                  w_blank_nxt;
  logic                  w_minus_nxt;
  logic [DIGITS-1:0]     w_en_nxt;

`ifdef LEADING_ZERO_BLANK_EN
  logic [IW-1:0]         r_msnz;
  logic [IW-1:0]         w_msnz_new;
  logic [IW-1:0]         w_msnz_nxt;
`endif

  assign w_tick      = (r_presc == PRESC_MAX);
  assign w_boundary  = w_tick && (r_index == LAST_IDX);
  // Load on the boundary cycle bypasses the pending register so digit 0 shows it at once.
  assign w_xfer      = w_boundary && (r_pending || load);
  assign w_xfer_val  = load ? value_in : r_pend_val;
  assign w_xfer_sign = load ? sign_in  : r_pend_sign;
  assign w_idx_nxt   = (r_index == LAST_IDX) ? '0 : r_index + 1'b1;
  assign w_shadow_nxt = w_xfer ? w_xfer_val  : r_shadow_val;
  assign w_sign_nxt   = w_xfer ? w_xfer_sign : r_shadow_sign;

`ifdef LEADING_ZERO_BLANK_EN
  // Highest nonzero digit of the incoming value; the sign position does not count.
  always_comb begin
    w_msnz_new = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if ((w_xfer_val[4*i +: 4] != 4'd0) && !((i == DIGITS - 1) && w_xfer_sign)) begin
        w_msnz_new = IW'(i);
      end
    end
  end
  assign w_msnz_nxt = w_xfer ? w_msnz_new : r_msnz;
`endif

  always_comb begin
    w_digit  = 4'd0;
    w_en_nxt = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (w_idx_nxt == IW'(i)) begin
        w_digit     = w_shadow_nxt[4*i +: 4];
        w_en_nxt[i] = 1'b1;
      end
    end
  end

  always_comb begin
    w_bcd_nxt   = 4'd0;
    w_blank_nxt = 1'b1;
    w_minus_nxt = 1'b0;
    if ((w_idx_nxt == LAST_IDX) && w_sign_nxt) begin
      w_minus_nxt = 1'b1;
    end else if (w_digit <= 4'd9) begin
      w_bcd_nxt   = w_digit;
      w_blank_nxt = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
      if (w_idx_nxt > w_msnz_nxt) begin
        w_bcd_nxt   = 4'd0;
        w_blank_nxt = 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc       <= '0;
      r_index       <= LAST_IDX;
      r_shadow_val  <= '0;
      r_shadow_sign <= 1'b0;
      r_pend_val    <= '0;
      r_pend_sign   <= 1'b0;
      r_pending     <= 1'b0;
      r_ack         <= 1'b0;
      r_bcd         <= 4'd0;
      r_blank       <= 1'b1;
      r_minus       <= 1'b0;
      r_digit_en    <= '0;
`ifdef LEADING_ZERO_BLANK_EN
      r_msnz        <= '0;
`endif
    end else begin
      r_presc <= w_tick ? '0 : r_presc + 1'b1;
      r_ack   <= w_xfer;
      if (w_xfer) begin
        r_shadow_val  <= w_xfer_val;
        r_shadow_sign <= w_xfer_sign;
        r_pending     <= 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        r_msnz        <= w_msnz_new;
`endif
      end else if (load) begin
        r_pend_val  <= value_in;
        r_pend_sign <= sign_in;
        r_pending   <= 1'b1;
      end
      if (w_tick) begin
        r_index    <= w_idx_nxt;
        r_bcd      <= w_bcd_nxt;
        r_blank    <= w_blank_nxt;
        r_minus    <= w_minus_nxt;
        r_digit_en <= w_en_nxt;
      end
    end
  end

  assign ack      = r_ack;
  assign bcd_out  = r_bcd;
  assign blank    = r_blank;
  assign minus    = r_minus;
  assign digit_en = r_digit_en;

endmodule

// File: tb/tb_display_scanner.sv
// tb/tb_display_scanner.sv - randomized scoreboard bench for display_scanner (DIGITS=4, REFRESH_DIV=4).
// Reference model honours LEADING_ZERO_BLANK_EN when defined.
module tb_display_scanner;

  logic        clk;
  logic        rst_n;
  logic [15:0] value_in;
  logic        sign_in;
  logic        load;
  logic        ack;
  logic [3:0]  bcd_out;
  logic        blank;
  logic        minus;
  logic [3:0]  digit_en;

  int tests;
  int fails;

  // Model state: edges since reset release, displayed value, pending request.
  int          m_n;
  logic [15:0] m_shadow;
  logic        m_sign;
  logic        m_pend;
  logic [15:0] m_pval;
  logic        m_psign;
  logic        m_ack;

  display_scanner #(.DIGITS(4), .REFRESH_DIV(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .value_in (value_in),
    .sign_in  (sign_in),
    .load     (load),
    .ack      (ack),
    .bcd_out  (bcd_out),
    .blank    (blank),
    .minus    (minus),
    .digit_en (digit_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s t=%0t n=%0d got=%0h exp=%0h", tag, $time, m_n, got, exp);
    end
  endtask

  task automatic model_reset();
    m_n = 0; m_shadow = '0; m_sign = 1'b0;
    m_pend = 1'b0; m_pval = '0; m_psign = 1'b0; m_ack = 1'b0;
  endtask

  // A frame starts on edges 4, 20, 36, ... after reset release.
  task automatic model_edge(input logic ld, input logic [15:0] v, input logic s);
    bit bnd;
    m_n++;
    bnd = (m_n % 16) == 4;
    m_ack = 1'b0;
    if (bnd && (ld || m_pend)) begin
      m_shadow = ld ? v : m_pval;
      m_sign   = ld ? s : m_psign;
      m_pend   = 1'b0;
      m_ack    = 1'b1;
    end else if (ld) begin
      m_pend = 1'b1; m_pval = v; m_psign = s;
    end
  endtask

  task automatic check_outputs();
    logic [3:0]  e_bcd, e_en, d;
    logic        e_blank, e_minus;
    logic [15:0] mag;
    int          idx;
    e_bcd = 4'd0; e_blank = 1'b1; e_minus = 1'b0; e_en = 4'd0;
    if (m_n >= 4) begin
      idx  = ((m_n / 4) - 1) % 4;
      e_en = 4'(1 << idx);
      d    = 4'((m_shadow >> (4 * idx)) & 16'hF);
      if (idx == 3 && m_sign) begin
        e_minus = 1'b1;
      end else if (d <= 4'd9) begin
        e_bcd = d; e_blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        mag = m_sign ? (m_shadow & 16'h0FFF) : m_shadow;
        if (idx != 0 && (mag >> (4 * idx)) == 16'h0) begin
          e_bcd = 4'd0; e_blank = 1'b1;
        end
`else
        mag = m_shadow;
`endif
      end
    end
    chk("digit_en", 32'(digit_en), 32'(e_en));
    chk("bcd_out", 32'(bcd_out), 32'(e_bcd));
    chk("blank", 32'(blank), 32'(e_blank));
    chk("minus", 32'(minus), 32'(e_minus));
    chk("ack", 32'(ack), 32'(m_ack));
    chk("bcd_range", 32'(bcd_out <= 4'd9), 32'd1);
  endtask

  task automatic cycle(input logic ld, input logic [15:0] v, input logic s);
    load = ld; value_in = v; sign_in = s;
    @(posedge clk);
    model_edge(ld, v, s);
    #1;
    check_outputs();
    load = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 16'($urandom), 1'($urandom));
  endtask

  // Advance until the next edge lands on the given phase within the frame.
  task automatic align(input int ph);
    for (int i = 0; i < 16 && ((m_n + 1) % 16) != ph; i++) idle(1);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_en"}, 32'(digit_en), 32'd0);
    chk({tag, "_blank"}, 32'(blank), 32'd1);
    chk({tag, "_bcd"}, 32'(bcd_out), 32'd0);
    chk({tag, "_minus"}, 32'(minus), 32'd0);
    chk({tag, "_ack"}, 32'(ack), 32'd0);
  endtask

  task automatic release_reset();
    @(negedge clk);
    #2 rst_n = 1'b1;
    model_reset();
  endtask

  function automatic logic [15:0] rand_value();
    logic [15:0] v;
    for (int i = 0; i < 4; i++)
      v[4*i +: 4] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 9));
    case ($urandom_range(0, 3))
      0: v = v & 16'h00FF;
      1: v = v & 16'h0FFF;
      2: v = v & 16'h000F;
      default: ;
    endcase
    return v;
  endfunction

  initial begin
    tests = 0; fails = 0;
    rst_n = 1'b0; load = 1'b0; value_in = '0; sign_in = 1'b0;
    model_reset();
    #12;
    check_reset_vals("rst");
    release_reset();

    idle(24);
    align(7);  cycle(1'b1, 16'h1234, 1'b0); idle(24);
    align(6);  cycle(1'b1, 16'h0007, 1'b0); idle(2);
    cycle(1'b1, 16'h0009, 1'b0); idle(24);
    align(4);  cycle(1'b1, 16'h0456, 1'b0); idle(18);
    align(9);  cycle(1'b1, 16'h0A05, 1'b1); idle(24);
    align(10); cycle(1'b1, 16'h0050, 1'b0); idle(24);
    align(4);  cycle(1'b1, 16'h9000, 1'b1); idle(20);

    // Asynchronous reset in the middle of a frame with a load pending.
    align(9);  cycle(1'b1, 16'h4321, 1'b0);
    #3 rst_n = 1'b0;
    #1 check_reset_vals("midrst");
    release_reset();
    idle(40);

    for (int k = 0; k < 2500; k++) begin
      if (k == 1300) begin
        #3 rst_n = 1'b0;
        #1 check_reset_vals("rndrst");
        release_reset();
      end
      cycle(1'($urandom_range(0, 15) == 0), rand_value(), 1'($urandom_range(0, 3) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/display_scanner.md
# display_scanner

Time-multiplexed scan controller for the calculator's multi-digit seven-segment display. It holds a frame-stable shadow copy of a packed BCD value and steps through the digit positions at a programmable refresh rate. For each position it presents one 4-bit code to the shared BCD-to-segment decoder, which only accepts codes 0–9, and drives the one-hot digit enable. It also produces blank and minus overrides for segment gating downstream.

## Interface
- DIGITS, 4: number of digit positions (≥2).
- REFRESH_DIV, 50000: clock cycles per digit slot (≥2).

- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- value_in  in  4*DIGITS  packed BCD; [3:0] is digit 0 (rightmost).
- sign_in  in  1  value is negative; sampled with value_in.
- load  in  1  one-cycle request to display value_in/sign_in.
- ack  out  1  one-cycle pulse when a load is transferred to the shadow register.
- bcd_out  out  4  code for the decoder's data input; always 0–9.
- blank  out  1  force all segments off for the current position.
- minus  out  1  force segment g on for the current position (used with blank=1).
- digit_en  out  DIGITS  one-hot active-high enable of the current position.

## Operation
- Reset values: prescaler=0, index=DIGITS-1, shadow value=0, shadow sign=0, pending=0, bcd_out=0, blank=1, minus=0, digit_en=0 (display dark), ack=0.
- Prescaler counts 0..REFRESH_DIV-1 and wraps. `tick` is true when count==REFRESH_DIV-1.
- On tick, index advances modulo DIGITS (DIGITS-1→0 is the frame boundary). All outputs are registered and updated on the tick edge from the new index.
- Load handshake:
  - load=1 captures value_in/sign_in into the pending register and sets the pending flag.
  - A load while pending overwrites the pending value (last write wins). Only one ack is issued.
  - At the frame-boundary tick, if pending is set, or load=1 on that same cycle (bypass, load data has priority), the data goes to the shadow, pending clears and ack=1 for exactly one cycle.
  - Digit 0 of that frame already shows the new value. No tearing within a frame.
- Per-position output, with d = the shadow digit at index:
  - If index==DIGITS-1 and shadow sign=1: blank=1, minus=1, bcd_out=0. The top digit's numeric content is ignored.
  - Else if d>9: blank=1, minus=0, bcd_out=0.
  - Else: bcd_out=d, blank=0, minus=0, unless suppressed by leading-zero blanking.
- digit_en = 1<<index after the first tick. It is never all-zero again until the next reset.
- Asynchronous reset mid-frame returns immediately to the reset values. Pending loads are discarded and no ack is issued.

## Timing
- First tick occurs REFRESH_DIV clock edges after rst_n deasserts. Outputs show index 0 from that edge.
- Each position is held for exactly REFRESH_DIV cycles. A frame lasts DIGITS*REFRESH_DIV cycles.
- Load-to-ack latency runs from 1 cycle (load on the boundary-tick cycle) up to DIGITS*REFRESH_DIV cycles.
- ack rises on the same edge as the digit-0 outputs of the new frame.

## Configuration
- LEADING_ZERO_BLANK_EN defined:
  - Positions above the most significant nonzero shadow digit that hold 0 are blanked (blank=1, bcd_out=0).
  - Digit 0 is never blanked.
  - The sign position (top digit when sign=1) keeps showing minus.
  - The most significant nonzero digit is computed from the shadow at transfer time.
- Undefined: every valid digit is displayed, including leading zeros.

## Test plan
All with DIGITS=4, REFRESH_DIV=4.
- Reset release → digit_en=0000, blank=1 for 3 edges. At edge 4: digit_en=0001, bcd_out=shadow digit 0=0. Then a one-hot rotation every 4 cycles: 0010, 0100, 1000, 0001.
- Load 16'h1234 mid-frame → ack exactly one cycle, coincident with digit_en=0001. Positions 0..3 then show 4,3,2,1. Digits shown before that edge keep the old value.
- Load 16'h0007, then 16'h0009 within the same frame → a single ack. Next frame shows 9 on digit 0.
- Load coincident with the boundary tick → ack on that same edge, and the new digit 0 is displayed immediately.
- Load 16'h0A05, sign=1 → position 2 gives blank=1, bcd_out=0. Position 3 gives blank=1, minus=1. bcd_out never exceeds 9.
- With LEADING_ZERO_BLANK_EN, load 16'h0050 → positions 0,1 show 0,5 unblanked; positions 2,3 blank. Without the macro, positions 2,3 show 0. Assert rst_n low mid-frame → all outputs return to reset values in the same cycle.
